fsm_encaixotamento: RTL and testbench
=====================================

# fsm_encaixotamento

Downstream packing stage of the bottling line: consumes the one-cycle approved-bottle pulse from the main line FSM, fills a 12-bottle crate, then runs a timed crate-sealing and crate-exchange sequence. While it is busy it holds the line with a back-pressure signal. It owns the dozen count shown on HEX3–HEX2 and the bottles-in-crate count.

## Interface
Parameters:
- GARRAFAS_POR_CAIXA, 12: bottles per crate (2..15).
- CICLOS_FECHAR, 50_000_000: sealing-actuator on-time in clk cycles (1 s at 50 MHz). Set small in simulation.
- MAX_DUZIAS, 99: saturation value of the dozen counter.

Ports (name, direction, width, meaning):
- clk, in, 1: 50 MHz system clock; the block's only clock.
- reset, in, 1: asynchronous, active-high reset.
- garrafa_aprovada, in, 1: one-cycle pulse per approved bottle.
- sensor_caixa, in, 1: level input; 1 = empty or partial crate present at the packing station.
- pausa_linha, out, 1: 1 = upstream must not deliver bottles.
- fechar_caixa, out, 1: crate-sealing actuator (LED).
- trocar_caixa, out, 1: request to remove the full crate (LED).
- alarme_sem_caixa, out, 1: no crate present while the block is waiting for one.
- erro_excesso, out, 1: sticky; a bottle was lost because a second one arrived while paused.
- caixa_pronta, out, 1: one-cycle pulse when sealing completes.
- contador_unidades, out, 4: bottles in the current crate, 0..GARRAFAS_POR_CAIXA-1.
- contador_duzias, out, 7: sealed crates, 0..MAX_DUZIAS.

## Operation
- States:
  - AGUARDA_CAIXA: pausa_linha=1; alarme_sem_caixa=1.
  - ENCHENDO: all actuators 0.
  - FECHANDO: pausa_linha=1; fechar_caixa=1.
  - EXPEDINDO: pausa_linha=1; trocar_caixa=1.
- Reset:
  - State is AGUARDA_CAIXA.
  - Counters are 0. erro_excesso=0. caixa_pronta=0. pendente=0.
  - Outputs follow the state decode above: pausa_linha=1, alarme_sem_caixa=1, all other outputs 0.
- AGUARDA_CAIXA → ENCHENDO when sensor_caixa=1.
- ENCHENDO:
  - Each garrafa_aprovada pulse increments contador_unidades.
  - On the pulse that would reach GARRAFAS_POR_CAIXA:
    - contador_unidades goes to 0.
    - contador_duzias increments, saturating at MAX_DUZIAS.
    - Next state is FECHANDO and the timer is loaded.
  - If sensor_caixa=0 and no pulse arrives in the same cycle: contador_unidades clears to 0 (the partial crate is discarded), next state is AGUARDA_CAIXA, and contador_duzias is unchanged.
  - If sensor_caixa=0 and a pulse arrives in the same cycle: the pulse is counted first, then the sensor rule applies (so the count still clears to 0).
- FECHANDO:
  - Stays for exactly CICLOS_FECHAR cycles.
  - In its last cycle caixa_pronta pulses; next state is EXPEDINDO.
- EXPEDINDO → AGUARDA_CAIXA when sensor_caixa=0, i.e. the full crate has been removed. A new crate then re-enters ENCHENDO via AGUARDA_CAIXA.
- Pulse received while pausa_linha=1:
  - First pulse sets the pendente flag.
  - Any further pulse while pendente=1 sets erro_excesso, which stays set until reset.
  - On entry to ENCHENDO with pendente=1, the first cycle counts that bottle (contador_unidades=1) and clears pendente.

## Timing
- All outputs are registered.
- Pulse at cycle N → contador_unidades updated at N+1.
- 12th pulse at cycle N:
  - State=FECHANDO, fechar_caixa=1 and contador_duzias+1, all at N+1.
  - fechar_caixa falls at N+1+CICLOS_FECHAR.
  - caixa_pronta=1 at N+CICLOS_FECHAR.
- pausa_linha rises in the same cycle as fechar_caixa. Upstream sees it one cycle late, which is why the one-deep pendente buffer exists.
- sensor_caixa is synchronised through two flip-flops inside the block. Sensor-driven transitions therefore occur 3 cycles after the pin changes.
- Reset is asynchronous. Asserting it mid-sealing drops fechar_caixa immediately and discards the timer and pendente.

## Structure
- Shared include vinho_defs.vh holds:
  - State encodings (2 bits: AGUARDA_CAIXA=0, ENCHENDO=1, FECHANDO=2, EXPEDINDO=3).
  - Default GARRAFAS_POR_CAIXA.
  - CLK_HZ=50_000_000.
- Sub-module temporizador_ciclos: a down-counter with a load input and a one-cycle fim output. Width is derived from CICLOS_FECHAR. It is reusable by the other timed FSMs.
- In the top level, this block replaces the direct garrafa_aprovada → contador_duzias_v2 path. contador_duzias feeds decodificador_display (HEX3/HEX2). pausa_linha goes to the main FSM.

## Test plan
- Reset with sensor_caixa=0 → AGUARDA_CAIXA, alarme_sem_caixa=1, pausa_linha=1, both counters 0.
- sensor_caixa=1, then 12 pulses spaced 5 cycles apart, CICLOS_FECHAR=8:
  - contador_unidades steps 1..11, then 0.
  - contador_duzias goes to 1.
  - fechar_caixa is high for exactly 8 cycles and caixa_pronta pulses once.
  - trocar_caixa=1 until sensor_caixa=0.
- Pulse one cycle after the 12th, while pausa_linha=1 → pendente is set; after crate swap and re-entry to ENCHENDO, contador_unidades=1 with no new pulse; erro_excesso stays 0.
- Two pulses during FECHANDO → erro_excesso=1, and it stays 1 through later crates until reset.
- sensor_caixa dropped at contador_unidades=7 in ENCHENDO → contador_unidades=0, AGUARDA_CAIXA, contador_duzias unchanged.
- Preload to 98 dozens and fill two crates → contador_duzias reads 99 after both crates (saturates, no wrap to 0).

Source files
------------

// File: rtl/fsm_encaixotamento_pkg.sv
// Shared types for the crate-packing stage of the bottling line.
// State encoding, output decode and line-wide constants.
package fsm_encaixotamento_pkg;

  typedef enum logic [1:0] {
    AGUARDA_CAIXA = 2'd0,
    ENCHENDO      = 2'd1,
    FECHANDO      = 2'd2,
    EXPEDINDO     = 2'd3
  } estado_t;

  localparam int GARRAFAS_PADRAO = 12;
  localparam int CLK_HZ          = 50_000_000;

  typedef struct packed {
    logic pausa;
    logic fechar;
    logic trocar;
    logic alarme;
  } saidas_t;

  function automatic saidas_t decodifica(estado_t e);
    saidas_t s;
    s = '0;
    unique case (e)
      AGUARDA_CAIXA: begin
        s.pausa  = 1'b1;
        s.alarme = 1'b1;
      end
      ENCHENDO: s = '0;
      FECHANDO: begin
        s.pausa  = 1'b1;
        s.fechar = 1'b1;
      end
      EXPEDINDO: begin
        s.pausa  = 1'b1;
        s.trocar = 1'b1;
      end
      default: s = '0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/temporizador_ciclos.sv
// Loadable down-counter; fim pulses (registered) in the
// CICLOS-th cycle after the load cycle.
module temporizador_ciclos #(
  parameter int CICLOS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic carregar,
  output logic fim
);

  localparam int W = (CICLOS > 1) ? $clog2(CICLOS) : 1;
  localparam logic [W-1:0] CARGA = W'(CICLOS - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         ativo_q, ativo_d;
  logic         fim_q, fim_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      ativo_q <= 1'b0;
      fim_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ativo_q <= ativo_d;
      fim_q   <= fim_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    ativo_d = ativo_q;
    if (carregar) begin
      cnt_d   = CARGA;
      ativo_d = 1'b1;
    end else if (ativo_q) begin
      if (cnt_q == '0) ativo_d = 1'b0;
      else cnt_d = cnt_q - W'(1);
    end
    fim_d = ativo_d && (cnt_d == '0);
  end

  assign fim = fim_q;

endmodule

// File: rtl/fsm_encaixotamento.sv
// Packing stage: fills a crate with approved bottles, seals it,
// waits for the exchange, and back-pressures the line meanwhile.
module fsm_encaixotamento
  import fsm_encaixotamento_pkg::*;
#(
  parameter int GARRAFAS_POR_CAIXA = GARRAFAS_PADRAO,
  parameter int CICLOS_FECHAR      = CLK_HZ,
  parameter int MAX_DUZIAS         = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       garrafa_aprovada,
  input  logic       sensor_caixa,
  output logic       pausa_linha,
  output logic       fechar_caixa,
  output logic       trocar_caixa,
  output logic       alarme_sem_caixa,
  output logic       erro_excesso,
  output logic       caixa_pronta,
  output logic [3:0] contador_unidades,
  output logic [6:0] contador_duzias
);

  localparam logic [3:0] ULTIMA  = 4'(GARRAFAS_POR_CAIXA - 1);
  localparam logic [6:0] DUZ_MAX = 7'(MAX_DUZIAS);

  estado_t    estado_q, estado_d;
  saidas_t    sai_q, sai_d;
  logic       s1_q, s2_q;
  logic [3:0] unid_q, unid_d;
  logic [6:0] duz_q, duz_d;
  logic       pend_q, pend_d;
  logic       erro_q, erro_d;
  logic       carregar;
  logic       fim;

  temporizador_ciclos #(
    .CICLOS(CICLOS_FECHAR)
  ) u_tmr (
    .clk     (clk),
    .reset   (reset),
    .carregar(carregar),
    .fim     (fim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= AGUARDA_CAIXA;
      sai_q    <= decodifica(AGUARDA_CAIXA);
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      unid_q   <= '0;
      duz_q    <= '0;
      pend_q   <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sai_q    <= sai_d;
      s1_q     <= sensor_caixa;
      s2_q     <= s1_q;
      unid_q   <= unid_d;
      duz_q    <= duz_d;
      pend_q   <= pend_d;
      erro_q   <= erro_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    unid_d   = unid_q;
    duz_d    = duz_q;
    pend_d   = pend_q;
    erro_d   = erro_q;
    carregar = 1'b0;

    // one-deep buffer for the bottle already in flight when we pause
    if (sai_q.pausa && garrafa_aprovada) begin
      if (pend_q) erro_d = 1'b1;
      else pend_d = 1'b1;
    end

    unique case (estado_q)
      AGUARDA_CAIXA: begin
        if (s2_q) begin
          estado_d = ENCHENDO;
          if (pend_q || garrafa_aprovada) unid_d = 4'd1;
          pend_d = 1'b0;
        end
      end
      ENCHENDO: begin
        if (garrafa_aprovada && unid_q == ULTIMA) begin
          unid_d   = '0;
          estado_d = FECHANDO;
          carregar = 1'b1;
          if (duz_q < DUZ_MAX) duz_d = duz_q + 7'd1;
        end else if (!s2_q) begin
          unid_d   = '0;
          estado_d = AGUARDA_CAIXA;
        end else if (garrafa_aprovada) begin
          unid_d = unid_q + 4'd1;
        end
      end
      FECHANDO: begin
        if (fim) estado_d = EXPEDINDO;
      end
      EXPEDINDO: begin
        if (!s2_q) estado_d = AGUARDA_CAIXA;
      end
      default: estado_d = AGUARDA_CAIXA;
    endcase

    sai_d = decodifica(estado_d);
  end

  assign pausa_linha       = sai_q.pausa;
  assign fechar_caixa      = sai_q.fechar;
  assign trocar_caixa      = sai_q.trocar;
  assign alarme_sem_caixa  = sai_q.alarme;
  assign erro_excesso      = erro_q;
  assign caixa_pronta      = fim;
  assign contador_unidades = unid_q;
  assign contador_duzias   = duz_q;

endmodule

// File: tb/tb_fsm_encaixotamento.sv
// Randomized bench for the packing stage: crate-level reference
// model feeds expectation queues popped by an output monitor.
module tb_fsm_encaixotamento;

  localparam int G   = 12;
  localparam int C   = 8;
  localparam int MAX = 99;

  logic       clk = 1'b0;
  logic       reset;
  logic       garrafa_aprovada;
  logic       sensor_caixa;
  logic       pausa_linha;
  logic       fechar_caixa;
  logic       trocar_caixa;
  logic       alarme_sem_caixa;
  logic       erro_excesso;
  logic       caixa_pronta;
  logic [3:0] contador_unidades;
  logic [6:0] contador_duzias;

  fsm_encaixotamento #(
    .GARRAFAS_POR_CAIXA(G),
    .CICLOS_FECHAR     (C),
    .MAX_DUZIAS        (MAX)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .garrafa_aprovada (garrafa_aprovada),
    .sensor_caixa     (sensor_caixa),
    .pausa_linha      (pausa_linha),
    .fechar_caixa     (fechar_caixa),
    .trocar_caixa     (trocar_caixa),
    .alarme_sem_caixa (alarme_sem_caixa),
    .erro_excesso     (erro_excesso),
    .caixa_pronta     (caixa_pronta),
    .contador_unidades(contador_unidades),
    .contador_duzias  (contador_duzias)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  int exp_unid[$];
  int exp_duz[$];

  // reference model: bottles in crate, dozens, buffer flag, error
  int m_unid = 0;
  int m_duz = 0;
  int m_pend = 0;
  int m_err = 0;
  int m_sealed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // output monitor
  logic [3:0] prev_unid = '0;
  int fech_cnt = 0;
  int pronta_seen = 0;

  always @(negedge clk) begin
    if (reset) begin
      prev_unid   = '0;
      fech_cnt    = 0;
      pronta_seen = 0;
    end else begin
      if (contador_unidades !== prev_unid) begin
        if (exp_unid.size() == 0)
          chk("unid_unexpected", 32'(contador_unidades), 32'(prev_unid));
        else
          chk("unid_step", 32'(contador_unidades), exp_unid.pop_front());
      end
      prev_unid = contador_unidades;
      if (fechar_caixa) begin
        fech_cnt++;
      end else if (fech_cnt != 0) begin
        chk("fechar_len", fech_cnt, C);
        fech_cnt = 0;
      end
      if (caixa_pronta) begin
        pronta_seen++;
        chk("pronta_at_last_seal_cycle", fech_cnt, C);
        if (exp_duz.size() == 0)
          chk("pronta_unexpected", 32'(contador_duzias), 32'h7f);
        else
          chk("duzias_at_pronta", 32'(contador_duzias), exp_duz.pop_front());
      end
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return pausa_linha;
      default: return trocar_caixa;
    endcase
  endfunction

  task automatic wait_sig(input string nm, input int sel,
                          input logic v, input int lim);
    int n = 0;
    while (sig(sel) !== v && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(sig(sel)), 32'(v));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_fill(output bit full);
    full = 0;
    garrafa_aprovada = 1'b1;
    m_unid++;
    if (m_unid == G) begin
      m_unid = 0;
      m_duz = (m_duz < MAX) ? m_duz + 1 : MAX;
      m_sealed++;
      exp_duz.push_back(m_duz);
      full = 1;
    end
    exp_unid.push_back(m_unid);
    @(negedge clk);
    garrafa_aprovada = 1'b0;
  endtask

  task automatic paused(input int k);
    for (int i = 0; i < k; i++) begin
      garrafa_aprovada = 1'b1;
      if (m_pend != 0) m_err = 1;
      else m_pend = 1;
      @(negedge clk);
      garrafa_aprovada = 1'b0;
      if (i < k - 1) idle($urandom_range(0, 1));
    end
  endtask

  // gap < 0 selects random spacing
  task automatic fill_crate(input int gap);
    bit full;
    forever begin
      pulse_fill(full);
      if (full) break;
      idle(gap < 0 ? $urandom_range(0, 3) : gap);
    end
  endtask

  task automatic enter_crate();
    sensor_caixa = 1'b1;
    if (m_pend != 0) begin
      m_unid = 1;
      exp_unid.push_back(1);
      m_pend = 0;
    end
    wait_sig("enter_enchendo", 0, 1'b0, 8);
  endtask

  task automatic swap_crate();
    wait_sig("trocar_rise", 1, 1'b1, C + 10);
    sensor_caixa = 1'b0;
    wait_sig("trocar_fall", 1, 1'b0, 8);
    enter_crate();
  endtask

  task automatic model_reset();
    exp_unid.delete();
    exp_duz.delete();
    m_unid = 0;
    m_duz = 0;
    m_pend = 0;
    m_err = 0;
    m_sealed = 0;
  endtask

  initial begin
    bit full;
    reset = 1'b1;
    garrafa_aprovada = 1'b0;
    sensor_caixa = 1'b0;
    idle(3);
    reset = 1'b0;
    idle(2);

    chk("rst_pausa", 32'(pausa_linha), 1);
    chk("rst_alarme", 32'(alarme_sem_caixa), 1);
    chk("rst_fechar", 32'(fechar_caixa), 0);
    chk("rst_trocar", 32'(trocar_caixa), 0);
    chk("rst_erro", 32'(erro_excesso), 0);
    chk("rst_pronta", 32'(caixa_pronta), 0);
    chk("rst_unid", 32'(contador_unidades), 0);
    chk("rst_duz", 32'(contador_duzias), 0);

    // first crate, 5-cycle spacing, one bottle caught in flight
    enter_crate();
    chk("enchendo_alarme", 32'(alarme_sem_caixa), 0);
    fill_crate(4);
    paused(1);
    swap_crate();
    chk("pend_no_error", 32'(erro_excesso), 0);
    chk("duz_after_1", 32'(contador_duzias), 32'(m_duz));

    // two bottles while sealing -> sticky overflow error
    fill_crate(-1);
    idle(1);
    paused(2);
    wait_sig("trocar_rise_err", 1, 1'b1, C + 10);
    chk("erro_set", 32'(erro_excesso), 32'(m_err));
    sensor_caixa = 1'b0;
    wait_sig("trocar_fall_err", 1, 1'b0, 8);
    enter_crate();

    fill_crate(-1);
    paused($urandom_range(0, 2));
    swap_crate();
    chk("erro_sticky", 32'(erro_excesso), 1);

    // crate removed mid-fill at 7 bottles
    while (m_unid < 7) begin
      pulse_fill(full);
      idle($urandom_range(0, 2));
    end
    sensor_caixa = 1'b0;
    if (m_unid != 0) exp_unid.push_back(0);
    m_unid = 0;
    wait_sig("drop_pausa", 0, 1'b1, 8);
    chk("drop_alarme", 32'(alarme_sem_caixa), 1);
    chk("drop_duz_kept", 32'(contador_duzias), 32'(m_duz));
    idle(2);
    chk("drop_unid", 32'(contador_unidades), 0);
    enter_crate();

    for (int r = 0; r < 3; r++) begin
      int tgt = $urandom_range(1, G - 1);
      while (m_unid < tgt) begin
        pulse_fill(full);
        idle($urandom_range(0, 2));
      end
      sensor_caixa = 1'b0;
      if (m_unid != 0) exp_unid.push_back(0);
      m_unid = 0;
      wait_sig("rand_drop", 0, 1'b1, 8);
      chk("rand_drop_duz", 32'(contador_duzias), 32'(m_duz));
      enter_crate();
    end

    // asynchronous reset in the middle of sealing
    fill_crate(-1);
    paused(1);
    idle(2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_fechar", 32'(fechar_caixa), 0);
    chk("async_rst_pausa", 32'(pausa_linha), 1);
    chk("async_rst_erro", 32'(erro_excesso), 0);
    model_reset();
    idle(2);
    reset = 1'b0;
    chk("async_rst_duz", 32'(contador_duzias), 0);
    enter_crate();
    idle(4);
    chk("pend_discarded", 32'(contador_unidades), 0);

    // climb to 98 dozens, then two more crates saturate
    while (m_duz < MAX - 1) begin
      fill_crate(-1);
      paused($urandom_range(0, 1));
      swap_crate();
    end
    chk("duz_98", 32'(contador_duzias), 98);
    for (int k = 0; k < 2; k++) begin
      fill_crate(-1);
      swap_crate();
      chk("duz_sat", 32'(contador_duzias), 32'(MAX));
    end

    idle(4);
    chk("unid_queue_drained", exp_unid.size(), 0);
    chk("duz_queue_drained", exp_duz.size(), 0);
    chk("pronta_count", pronta_seen, m_sealed);
    chk("final_erro", 32'(erro_excesso), 32'(m_err));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
